// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback arbiter slice.
package wb_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int DATA_W     = 32;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a writeback producer: load wins over free.
module wb_slot
    import wb_pkg::*;
#(
    parameter int RD_W  = REG_ADDR_W,
    parameter int VAL_W = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [RD_W-1:0]  load_rd,
    input  logic [VAL_W-1:0] load_data,
    input  logic             free,
    output logic             occupied,
    output logic [RD_W-1:0]  rd,
    output logic [VAL_W-1:0] data
);

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupied <= 1'b0;
            rd       <= '0;
            data     <= '0;
        end else if (load) begin
            occupied <= 1'b1;
            rd       <= load_rd;
            data     <= load_data;
        end else if (free) begin
            occupied <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: two producer slots share one registered
// register-file write port, with a pending-destination mask for hazard stalls.
module wb_arbiter #(
    parameter int  NUM_REGS = wb_pkg::NUM_REGS,
    parameter int  DATA_W   = wb_pkg::DATA_W,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_wb_valid,
    input  logic [ADDR_W-1:0]   alu_wb_rd,
    input  logic [DATA_W-1:0]   alu_wb_data,
    output logic                alu_wb_ready,
    input  logic                mem_wb_valid,
    input  logic [ADDR_W-1:0]   mem_wb_rd,
    input  logic [DATA_W-1:0]   mem_wb_data,
    output logic                mem_wb_ready,
    output logic                register_write_en,
    output logic [ADDR_W-1:0]   rd_address,
    output logic [DATA_W-1:0]   register_write_data,
    output logic [NUM_REGS-1:0] pending_mask
);

    import wb_pkg::*;

    logic              alu_occ, mem_occ;
    logic [ADDR_W-1:0] alu_rd, mem_rd;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              alu_grant, mem_grant;
    logic              alu_conflict, mem_conflict;
    logic              alu_load, mem_load;
    grant_t            prio;

    assign alu_grant = alu_occ && (!mem_occ || prio == GRANT_ALU);
    assign mem_grant = mem_occ && (!alu_occ || prio == GRANT_MEM);

    // A same-destination write must wait until the older one in the other
    // slot drains, otherwise the two could retire out of program order.
    assign alu_conflict = (alu_wb_rd != '0) && mem_occ && (mem_rd == alu_wb_rd) && !mem_grant;
    assign mem_conflict = (mem_wb_rd != '0) && alu_occ && (alu_rd == mem_wb_rd) && !alu_grant;

    assign alu_wb_ready = (!alu_occ || alu_grant) && !alu_conflict && rst;
    assign mem_wb_ready = (!mem_occ || mem_grant) && !mem_conflict && rst;

    // Writes to x0 complete the handshake but are dropped here.
    assign alu_load = alu_wb_valid && alu_wb_ready && (alu_wb_rd != '0);
    assign mem_load = mem_wb_valid && mem_wb_ready && (mem_wb_rd != '0);

    wb_slot #(.RD_W(ADDR_W), .VAL_W(DATA_W)) u_alu_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (alu_load),
        .load_rd   (alu_wb_rd),
        .load_data (alu_wb_data),
        .free      (alu_grant),
        .occupied  (alu_occ),
        .rd        (alu_rd),
        .data      (alu_data)
    );

    wb_slot #(.RD_W(ADDR_W), .VAL_W(DATA_W)) u_mem_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (mem_load),
        .load_rd   (mem_wb_rd),
        .load_data (mem_wb_data),
        .free      (mem_grant),
        .occupied  (mem_occ),
        .rd        (mem_rd),
        .data      (mem_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            register_write_en   <= 1'b0;
            rd_address          <= '0;
            register_write_data <= '0;
            prio                <= GRANT_MEM;
        end else begin
            register_write_en <= alu_grant || mem_grant;
            if (alu_grant) begin
                rd_address          <= alu_rd;
                register_write_data <= alu_data;
            end else if (mem_grant) begin
                rd_address          <= mem_rd;
                register_write_data <= mem_data;
            end
            // Only a contested grant rotates priority.
            if (alu_occ && mem_occ) begin
                prio <= alu_grant ? GRANT_MEM : GRANT_ALU;
            end
        end
    end

    // NOTE: the mask starts from a full default so no path through this
    // block leaves a bit unassigned and infers a latch.
    always_comb begin
        pending_mask = '0;
        if (alu_occ)           pending_mask[alu_rd]     = 1'b1;
        if (mem_occ)           pending_mask[mem_rd]     = 1'b1;
        if (register_write_en) pending_mask[rd_address] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that shares the register file's single write port between two producers: the ALU result path and the memory-load result path. Each producer hands off `{rd, data}` over a valid/ready handshake into a one-entry holding slot. A round-robin arbiter drains one slot per cycle into a registered write stage that drives the register file's `register_write_en` / `rd_address` / `register_write_data` inputs directly. A pending-destination mask is exported so decode can stall on RAW hazards against in-flight writebacks.

## Interface
- `NUM_REGS`, default 32: architectural registers; address width is clog2(NUM_REGS).
- `DATA_W`, default 32: register data width.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, all state on posedge.
- `rst`  in  1  asynchronous active-low reset.
- `alu_wb_valid`  in  1  ALU result offered.
- `alu_wb_rd`  in  5  ALU destination register.
- `alu_wb_data`  in  32  ALU result.
- `alu_wb_ready`  out  1  ALU handshake accept.
- `mem_wb_valid`, `mem_wb_rd`, `mem_wb_data`, `mem_wb_ready`: same widths and meaning, for the load path.
- `register_write_en`  out  1  register file write strobe (registered).
- `rd_address`  out  5  register file write address (registered).
- `register_write_data`  out  32  register file write data (registered).
- `pending_mask`  out  32  bit r high while a write to r is held in a slot or in the write stage.

## Operation
- Handshake: a transfer occurs on a posedge where valid && ready. Producers hold rd and data stable while valid && !ready.
- Slot: one entry per requester, holding `{occupied, rd, data}`.
- `x_wb_ready` = (slot empty OR slot granted this cycle) AND NOT conflict AND rst high.
- Conflict: incoming rd ≠ 0, it equals the rd of the other requester's occupied slot, and that slot is not granted this cycle. Blocking on conflict preserves program order for same-destination writes.
- x0 handling: a transfer with rd = 0 completes, but the slot is not loaded. No write occurs and `pending_mask` is unaffected.
- Arbitration:
  - One slot occupied: that slot is granted.
  - Both slots occupied: the grant goes to the requester named by the `prio` pointer. Types: `grant_t` = {GRANT_ALU, GRANT_MEM}.
  - After a contested grant, `prio` flips to the other requester. An uncontested grant leaves `prio` unchanged.
  - `prio` resets to GRANT_MEM.
- Write stage: on each posedge, `register_write_en` <= grant exists, and `rd_address` / `register_write_data` <= the granted slot's contents. The granted slot frees on the same edge, or reloads if its producer hands off simultaneously.
- `pending_mask` is combinational from registered state: the OR of one-hot(rd) over the occupied slots and over the write stage when `register_write_en` = 1. Bit 0 is always 0.

## Timing
- Reset values: both slots empty, `register_write_en` = 0, `rd_address` = 0, `register_write_data` = 0, `prio` = GRANT_MEM, `pending_mask` = 0. Both ready outputs are 0 while rst is low.
- Latency, uncontested: handshake at edge E → `register_write_en` high in the cycle after edge E+1 → register file captures at edge E+2.
- Throughput: one write per cycle total. A single uncontested requester sustains one transfer per cycle.
- Contested: the losing slot is granted on the following edge. Its producer sees ready = 0 for that one cycle.
- Reset mid-operation: all held entries are discarded immediately (asynchronous). No write is issued after reset deasserts until new handshakes occur.
- The register file forwards the write to its read ports in the same cycle, so the write stage needs no bypass here.

## Structure
- Package `wb_pkg`:
  - `grant_t` enum.
  - `wb_req_t` packed struct {rd, data}.
  - `NUM_REGS`, `REG_ADDR_W` constants.
- Sub-module `wb_slot`: one-entry holding register with load/free/occupied, instantiated twice (ALU, MEM).
- The top level holds the arbiter, the `prio` flop, the write stage and the `pending_mask` logic.

## Test plan
- ALU only: rd = 5, data = 0xDEADBEEF → `register_write_en` = 1, `rd_address` = 5, `register_write_data` = 0xDEADBEEF one cycle after the handshake edge. `pending_mask[5]` is high for exactly 2 cycles.
- Both valid on the same edge: MEM rd = 3, ALU rd = 7 → write rd 3, then rd 7 on consecutive cycles; `alu_wb_ready` is low for 1 cycle. Repeat with rd = 4 and rd = 8 → rd 8 (ALU) is written first.
- ALU rd = 0, data = 0x1234 → `alu_wb_ready` = 1, no `register_write_en` pulse, `pending_mask` stays 0.
- Same destination: a MEM entry with rd = 9 is held losing arbitration, and ALU offers rd = 9 → `alu_wb_ready` stays 0 until the MEM slot is granted. Writes are MEM then ALU, both to rd 9, in order.
- Uncontested ALU stream rd = 1..4 with data = rd*0x11 on back-to-back cycles → four consecutive write cycles with no ready deassertion.
- rst driven low with both slots full and the write stage active → all outputs and `pending_mask` go to 0 immediately. After release, no spurious write appears in the next 3 cycles.
